// File: rtl/ifid_register.sv
// IF/ID pipeline register: captures fetch output, inserts stall/flush bubbles,
// and carries branch-delay-slot status across fetch bubbles.
module ifid_register (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IF_Instruction,
    input  logic [31:0] IF_PC,
    input  logic [31:0] IF_PCAdd4,
    input  logic        IF_Stall,
    input  logic        IF_Flush,
    input  logic        ID_Stall,
    input  logic        ID_NextIsDelay,
    output logic [31:0] ID_Instruction,
    output logic [31:0] ID_PCAdd4,
    output logic [31:0] ID_RestartPC,
    output logic        ID_IsBDS,
    output logic        ID_IsFlushed,
    output logic        IF_PendingBDS
);

    logic        pendBds;
    logic [31:0] pendRestart;
    logic        bdsIn;
    logic [31:0] bdsRpc;

    assign bdsIn  = ID_NextIsDelay | pendBds;
    // A branch currently in ID takes precedence over a remembered one
    assign bdsRpc = ID_NextIsDelay ? ID_RestartPC : pendRestart;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ID_Instruction <= 32'h0;
            ID_PCAdd4      <= 32'h0;
            ID_RestartPC   <= 32'h0;
            ID_IsBDS       <= 1'b0;
            ID_IsFlushed   <= 1'b0;
            pendBds        <= 1'b0;
            pendRestart    <= 32'h0;
        end else if (ID_Stall) begin
            if (IF_Flush)
                pendBds <= 1'b0;
        end else if (IF_Flush) begin
            ID_Instruction <= 32'h0;
            ID_PCAdd4      <= IF_PCAdd4;
            ID_RestartPC   <= IF_PC;
            ID_IsBDS       <= 1'b0;
            ID_IsFlushed   <= 1'b1;
            pendBds        <= 1'b0;
        end else if (IF_Stall) begin
            ID_Instruction <= 32'h0;
            ID_PCAdd4      <= IF_PCAdd4;
            ID_RestartPC   <= IF_PC;
            ID_IsBDS       <= 1'b0;
            ID_IsFlushed   <= 1'b0;
            // Branch leaves ID before its delay slot arrives: remember it
            if (ID_NextIsDelay) begin
                pendBds     <= 1'b1;
                pendRestart <= ID_RestartPC;
            end
        end else begin
            ID_Instruction <= IF_Instruction;
            ID_PCAdd4      <= IF_PCAdd4;
            ID_RestartPC   <= bdsIn ? bdsRpc : IF_PC;
            ID_IsBDS       <= bdsIn;
            ID_IsFlushed   <= 1'b0;
            pendBds        <= 1'b0;
        end
    end

    assign IF_PendingBDS = pendBds;

endmodule

// File: tb/tb_ifid_register.sv
// Directed self-checking bench for ifid_register.
// Each scenario task drives vectors and checks hand-computed values.
module tb_ifid_register;

    logic        clock;
    logic        reset;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PC;
    logic [31:0] IF_PCAdd4;
    logic        IF_Stall;
    logic        IF_Flush;
    logic        ID_Stall;
    logic        ID_NextIsDelay;
    logic [31:0] ID_Instruction;
    logic [31:0] ID_PCAdd4;
    logic [31:0] ID_RestartPC;
    logic        ID_IsBDS;
    logic        ID_IsFlushed;
    logic        IF_PendingBDS;

    int checks = 0;
    int errors = 0;

    ifid_register dut (
        .clock         (clock),
        .reset         (reset),
        .IF_Instruction(IF_Instruction),
        .IF_PC         (IF_PC),
        .IF_PCAdd4     (IF_PCAdd4),
        .IF_Stall      (IF_Stall),
        .IF_Flush      (IF_Flush),
        .ID_Stall      (ID_Stall),
        .ID_NextIsDelay(ID_NextIsDelay),
        .ID_Instruction(ID_Instruction),
        .ID_PCAdd4     (ID_PCAdd4),
        .ID_RestartPC  (ID_RestartPC),
        .ID_IsBDS      (ID_IsBDS),
        .ID_IsFlushed  (ID_IsFlushed),
        .IF_PendingBDS (IF_PendingBDS)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic setIf(input logic [31:0] instr, input logic [31:0] pc);
        IF_Instruction = instr;
        IF_PC          = pc;
        IF_PCAdd4      = pc + 32'd4;
    endtask

    task automatic test_reset();
        checks++;
        if (ID_Instruction !== 32'h0 || ID_RestartPC !== 32'h0 || ID_PCAdd4 !== 32'h0 ||
            ID_IsBDS !== 1'b0 || ID_IsFlushed !== 1'b0 || IF_PendingBDS !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: instr=%h rpc=%h pc4=%h bds=%b fl=%b pend=%b, expected all 0",
                     ID_Instruction, ID_RestartPC, ID_PCAdd4, ID_IsBDS, ID_IsFlushed, IF_PendingBDS);
        end
        reset = 1'b0;
        setIf(32'hDEADBEEF, 32'h40);
        step();
        checks++;
        if (ID_Instruction !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL pre_reset_load: got %h expected deadbeef", ID_Instruction);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (ID_Instruction !== 32'h0 || ID_RestartPC !== 32'h0 || ID_PCAdd4 !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: instr=%h rpc=%h pc4=%h expected 0",
                     ID_Instruction, ID_RestartPC, ID_PCAdd4);
        end
        #1 reset = 1'b0;
        setIf(32'h24080005, 32'h100);
        step();
        checks++;
        if (ID_Instruction !== 32'h24080005 || ID_PCAdd4 !== 32'h104 ||
            ID_RestartPC !== 32'h100 || ID_IsBDS !== 1'b0 || ID_IsFlushed !== 1'b0) begin
            errors++;
            $display("FAIL first_capture: instr=%h pc4=%h rpc=%h bds=%b fl=%b expected 24080005 104 100 0 0",
                     ID_Instruction, ID_PCAdd4, ID_RestartPC, ID_IsBDS, ID_IsFlushed);
        end
    endtask

    task automatic test_normal_bds();
        setIf(32'h10000003, 32'h200);
        step();
        checks++;
        if (ID_RestartPC !== 32'h200 || ID_IsBDS !== 1'b0) begin
            errors++;
            $display("FAIL branch_load: rpc=%h bds=%b expected 200 0", ID_RestartPC, ID_IsBDS);
        end
        ID_NextIsDelay = 1'b1;
        setIf(32'h01095020, 32'h204);
        step();
        ID_NextIsDelay = 1'b0;
        checks++;
        if (ID_IsBDS !== 1'b1 || ID_RestartPC !== 32'h200 || ID_PCAdd4 !== 32'h208 ||
            ID_Instruction !== 32'h01095020) begin
            errors++;
            $display("FAIL normal_bds: bds=%b rpc=%h pc4=%h instr=%h expected 1 200 208 01095020",
                     ID_IsBDS, ID_RestartPC, ID_PCAdd4, ID_Instruction);
        end
    endtask

    task automatic test_late_bds();
        setIf(32'h10000003, 32'h200);
        step();
        ID_NextIsDelay = 1'b1;
        IF_Stall = 1'b1;
        setIf(32'hFFFFFFFF, 32'h204);
        for (int i = 0; i < 3; i++) begin
            step();
            ID_NextIsDelay = 1'b0;
            checks++;
            if (ID_Instruction !== 32'h0 || ID_IsBDS !== 1'b0 || IF_PendingBDS !== 1'b1 ||
                ID_RestartPC !== 32'h204 || ID_IsFlushed !== 1'b0) begin
                errors++;
                $display("FAIL late_bubble%0d: instr=%h bds=%b pend=%b rpc=%h fl=%b expected 0 0 1 204 0",
                         i, ID_Instruction, ID_IsBDS, IF_PendingBDS, ID_RestartPC, ID_IsFlushed);
            end
        end
        IF_Stall = 1'b0;
        setIf(32'h01095020, 32'h204);
        step();
        checks++;
        if (ID_IsBDS !== 1'b1 || ID_RestartPC !== 32'h200 || IF_PendingBDS !== 1'b0 ||
            ID_Instruction !== 32'h01095020) begin
            errors++;
            $display("FAIL late_bds: bds=%b rpc=%h pend=%b instr=%h expected 1 200 0 01095020",
                     ID_IsBDS, ID_RestartPC, IF_PendingBDS, ID_Instruction);
        end
    endtask

    task automatic test_id_stall();
        ID_Stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            setIf(32'hA0000000 + i, 32'h600 + 32'(i * 4));
            step();
            checks++;
            if (ID_Instruction !== 32'h01095020 || ID_RestartPC !== 32'h200 ||
                ID_PCAdd4 !== 32'h208 || ID_IsBDS !== 1'b1 || ID_IsFlushed !== 1'b0) begin
                errors++;
                $display("FAIL id_stall_hold%0d: instr=%h rpc=%h pc4=%h bds=%b expected 01095020 200 208 1",
                         i, ID_Instruction, ID_RestartPC, ID_PCAdd4, ID_IsBDS);
            end
        end
        ID_Stall = 1'b0;
        setIf(32'h8D090010, 32'h208);
        step();
        checks++;
        if (ID_Instruction !== 32'h8D090010 || ID_RestartPC !== 32'h208 ||
            ID_PCAdd4 !== 32'h20C || ID_IsBDS !== 1'b0) begin
            errors++;
            $display("FAIL id_stall_release: instr=%h rpc=%h pc4=%h bds=%b expected 8d090010 208 20c 0",
                     ID_Instruction, ID_RestartPC, ID_PCAdd4, ID_IsBDS);
        end
    endtask

    task automatic test_flush();
        setIf(32'h08000100, 32'h300);
        step();
        ID_NextIsDelay = 1'b1;
        IF_Stall = 1'b1;
        setIf(32'h0, 32'h304);
        step();
        ID_NextIsDelay = 1'b0;
        checks++;
        if (IF_PendingBDS !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup_pend: got %b expected 1", IF_PendingBDS);
        end
        IF_Flush = 1'b1;
        step();
        IF_Flush = 1'b0;
        IF_Stall = 1'b0;
        checks++;
        if (ID_Instruction !== 32'h0 || ID_IsFlushed !== 1'b1 || IF_PendingBDS !== 1'b0 ||
            ID_IsBDS !== 1'b0 || ID_RestartPC !== 32'h304) begin
            errors++;
            $display("FAIL flush_bubble: instr=%h fl=%b pend=%b bds=%b rpc=%h expected 0 1 0 0 304",
                     ID_Instruction, ID_IsFlushed, IF_PendingBDS, ID_IsBDS, ID_RestartPC);
        end
        setIf(32'h3C1A8000, 32'h80000180);
        step();
        checks++;
        if (ID_IsBDS !== 1'b0 || ID_RestartPC !== 32'h80000180 || ID_IsFlushed !== 1'b0 ||
            ID_Instruction !== 32'h3C1A8000) begin
            errors++;
            $display("FAIL post_flush: bds=%b rpc=%h fl=%b instr=%h expected 0 80000180 0 3c1a8000",
                     ID_IsBDS, ID_RestartPC, ID_IsFlushed, ID_Instruction);
        end
    endtask

    task automatic test_flush_under_stall();
        setIf(32'h10000007, 32'h400);
        step();
        ID_NextIsDelay = 1'b1;
        IF_Stall = 1'b1;
        setIf(32'h0, 32'h404);
        step();
        ID_NextIsDelay = 1'b0;
        IF_Stall = 1'b0;
        ID_Stall = 1'b1;
        IF_Flush = 1'b1;
        setIf(32'h12345678, 32'h500);
        step();
        checks++;
        if (ID_Instruction !== 32'h0 || ID_RestartPC !== 32'h404 || ID_IsFlushed !== 1'b0 ||
            IF_PendingBDS !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall_hold: instr=%h rpc=%h fl=%b pend=%b expected 0 404 0 0",
                     ID_Instruction, ID_RestartPC, ID_IsFlushed, IF_PendingBDS);
        end
        ID_Stall = 1'b0;
        step();
        IF_Flush = 1'b0;
        checks++;
        if (ID_IsFlushed !== 1'b1 || ID_Instruction !== 32'h0 || ID_RestartPC !== 32'h500 ||
            ID_IsBDS !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall_release: fl=%b instr=%h rpc=%h bds=%b expected 1 0 500 0",
                     ID_IsFlushed, ID_Instruction, ID_RestartPC, ID_IsBDS);
        end
        setIf(32'h24090001, 32'h504);
        step();
        checks++;
        if (ID_IsBDS !== 1'b0 || ID_RestartPC !== 32'h504 || ID_IsFlushed !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall_next: bds=%b rpc=%h fl=%b expected 0 504 0",
                     ID_IsBDS, ID_RestartPC, ID_IsFlushed);
        end
    endtask

    initial begin
        reset          = 1'b1;
        IF_Stall       = 1'b0;
        IF_Flush       = 1'b0;
        ID_Stall       = 1'b0;
        ID_NextIsDelay = 1'b0;
        setIf(32'h0, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_normal_bds();
        test_late_bds();
        test_id_stall();
        test_flush();
        test_flush_under_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifid_register.md
# ifid_register

IF/ID pipeline register for the MIPS32 core. It captures the fetched instruction and its PC context every cycle and drives the ID stage's `ID_Instruction`, `ID_PCAdd4`, `ID_RestartPC`, `ID_IsBDS` and `ID_IsFlushed` signals. It inserts bubbles on fetch stalls and flushes. It also carries branch-delay-slot (BDS) status across fetch bubbles, so a delay slot that arrives late is still tagged with the restart PC of its branch.

## Interface
Parameters: none (fixed 32-bit datapath).
- clock  in  1  core clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- IF_Instruction  in  32  instruction word from instruction memory
- IF_PC  in  32  PC of `IF_Instruction`
- IF_PCAdd4  in  32  `IF_PC + 4`
- IF_Stall  in  1  instruction memory not ready; `IF_Instruction` is invalid this cycle
- IF_Flush  in  1  exception/eret flush of the fetch slot
- ID_Stall  in  1  ID stage cannot accept a new instruction
- ID_NextIsDelay  in  1  from the controller: the instruction currently in ID is a branch or jump
- ID_Instruction  out  32  registered instruction; 0 (sll nop) for a bubble
- ID_PCAdd4  out  32  registered `IF_PCAdd4`
- ID_RestartPC  out  32  PC at which to restart if this instruction faults
- ID_IsBDS  out  1  instruction in ID is a branch delay slot
- ID_IsFlushed  out  1  ID holds a bubble created by `IF_Flush`
- IF_PendingBDS  out  1  the next delivered instruction will be tagged as a BDS

## Operation
Internal state: `pend_bds` (1 bit) and `pend_restart` (32 bits).

Derived signals:
- `advance = ~ID_Stall`
- `bds_in = ID_NextIsDelay | pend_bds`
- `bds_rpc = ID_NextIsDelay ? ID_RestartPC : pend_restart`

Per-cycle behaviour, in priority order:
- **reset:** all outputs, `pend_bds` and `pend_restart` go to 0.
- **ID_Stall=1:** all `ID_*` outputs hold. `pend_restart` holds. `pend_bds` is cleared if `IF_Flush=1`, otherwise it holds. The upstream stage keeps `IF_Flush` asserted until the flush is honoured.
- **advance & IF_Flush (flush bubble):**
  - `ID_Instruction`=0, `ID_IsFlushed`=1, `ID_IsBDS`=0
  - `ID_RestartPC`=`IF_PC`, `ID_PCAdd4`=`IF_PCAdd4`
  - `pend_bds`=0
  - `IF_Flush` wins over `IF_Stall`.
- **advance & IF_Stall & ~IF_Flush (stall bubble):**
  - `ID_Instruction`=0, `ID_IsFlushed`=0, `ID_IsBDS`=0
  - `ID_RestartPC`=`IF_PC`, `ID_PCAdd4`=`IF_PCAdd4`
  - If `ID_NextIsDelay`=1: `pend_bds`=1 and `pend_restart`=current `ID_RestartPC`. Otherwise pending state holds.
- **advance & ~IF_Stall & ~IF_Flush (deliver):**
  - `ID_Instruction`=`IF_Instruction`, `ID_PCAdd4`=`IF_PCAdd4`, `ID_IsFlushed`=0
  - `ID_IsBDS`=`bds_in`
  - `ID_RestartPC`=`bds_in ? bds_rpc : IF_PC`
  - `pend_bds`=0

Additional rules:
- `IF_PendingBDS` = `pend_bds` (registered; no combinational path).
- A bubble (instruction 0) never causes `ID_NextIsDelay`, so `pend_bds` can only be set by a real branch leaving ID.
- If `ID_NextIsDelay` and `pend_bds` are both 1, `ID_NextIsDelay` selects the restart PC. This case is illegal (a branch in a delay slot) but its behaviour is still defined.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on `ID_*` after edge N.
- There are no combinational paths from inputs to outputs.
- `reset` asserted mid-operation clears outputs immediately, without waiting for a clock edge. The first capture happens on the first rising edge after `reset` is deasserted.
- Stall cycles may be consecutive without limit. Pending BDS state survives any number of `IF_Stall` bubbles and any number of `ID_Stall` cycles. Only a delivery, an `IF_Flush` or `reset` clears it.
- Each input is sampled once per edge; there is no internal handshake buffering.

## Test plan
- **Reset:** assert `reset` mid-cycle with outputs nonzero → all outputs read 0 before the next edge. Release `reset`, drive `IF_Instruction`=0x2408_0005 and `IF_PC`=0x100 → after one edge `ID_Instruction`=0x2408_0005, `ID_PCAdd4`=0x104, `ID_RestartPC`=0x100, `ID_IsBDS`=0.
- **Normal BDS:** ID holds a branch with `ID_RestartPC`=0x200 and `ID_NextIsDelay`=1; deliver `IF_PC`=0x204 → `ID_IsBDS`=1, `ID_RestartPC`=0x200.
- **Late BDS:** branch in ID (restart PC 0x200) with `IF_Stall`=1 for 3 cycles → 3 bubbles with `ID_IsBDS`=0 and `IF_PendingBDS`=1. Then deliver `IF_PC`=0x204 → `ID_IsBDS`=1, `ID_RestartPC`=0x200, `IF_PendingBDS`=0.
- **ID stall hold:** `ID_Stall`=1 for 2 cycles while `IF_Instruction` changes → all `ID_*` outputs unchanged. Release → next IF word is captured.
- **Flush:** `IF_Flush`=1 and `IF_Stall`=1 with `pend_bds`=1 → `ID_Instruction`=0, `ID_IsFlushed`=1, `IF_PendingBDS`=0. A following delivery at `IF_PC`=0x80000180 → `ID_IsBDS`=0, `ID_RestartPC`=0x80000180.
- **Flush under stall:** `IF_Flush`=1 with `ID_Stall`=1 → outputs hold and `pend_bds` clears. Keep `IF_Flush`=1 and drop `ID_Stall` → `ID_IsFlushed`=1.
